rf_wb_arbiter: RTL and testbench

- Shares the register file's single general write port among NREQ writeback requesters (ALU, load unit, multiplier) using round-robin arbitration and a valid/ready handshake.
- Forwards PC updates to the register file's PC port with absolute priority. When a PC update is present, no general write is granted, so a general write is never silently dropped.
- Keeps a pending-write scoreboard, one bit per register, so issue logic can detect RAW hazards on the two read operands.

---
 rtl/rf_wb_arbiter.sv | 117 +++++++++++
 tb/tb_rf_wb_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the general write port,
// a PC port that always wins, and a per-register pending-write scoreboard.
module rf_wb_arbiter #(
  parameter int DW   = 16,
  parameter int AW   = 4,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 pc_valid,
  input  logic [AW-1:0]        pc_addr,
  input  logic [DW-1:0]        pc_data,
  input  logic                 issue_en,
  input  logic [AW-1:0]        issue_addr,
  input  logic                 flush,
  input  logic [AW-1:0]        chk1_addr,
  input  logic [AW-1:0]        chk2_addr,
  output logic                 hazard1,
  output logic                 hazard2,
  output logic [(2**AW)-1:0]   pending,
  output logic                 w_en,
  output logic [AW-1:0]        w_addr,
  output logic [DW-1:0]        w_data,
  output logic                 pc_en,
  output logic [AW-1:0]        pc_addr_o,
  output logic [DW-1:0]        pc_data_o
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int NR = 2**AW;

  // Handshake: requester i transfers when req_valid[i] & req_ready[i] on a rising
  // edge; it keeps valid/addr/data stable until then. req_ready is one-hot or zero.
  logic [IW-1:0]   last;
  logic [NREQ-1:0] grant;
  logic            xfer;
  logic [IW-1:0]   sel_idx;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic [NR-1:0]   pending_nxt;

  always_comb begin : grant_scan
    int  idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = int'(last) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    // PC update or flush owns this cycle; the requester simply waits.
    if (!rst_n || pc_valid || flush) grant = '0;
  end

  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx  = IW'(i);
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DW +: DW];
      end
    end
  end

  assign xfer      = |grant;
  assign req_ready = grant;

  // Clear comes from the write leaving on this edge; a same-cycle issue re-sets it.
  always_comb begin
    pending_nxt = pending;
    if (w_en) pending_nxt[w_addr] = 1'b0;
    if (issue_en) pending_nxt[issue_addr] = 1'b1;
    if (flush) pending_nxt = '0;
  end

  assign hazard1 = pending[chk1_addr];
  assign hazard2 = pending[chk2_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last      <= IW'(NREQ - 1);
      pending   <= '0;
      w_en      <= 1'b0;
      w_addr    <= '0;
      w_data    <= '0;
      pc_en     <= 1'b0;
      pc_addr_o <= '0;
      pc_data_o <= '0;
    end else begin
      pending <= pending_nxt;
      w_en    <= xfer;
      if (xfer) begin
        last   <= sel_idx;
        w_addr <= sel_addr;
        w_data <= sel_data;
      end
      pc_en <= pc_valid;
      if (pc_valid) begin
        pc_addr_o <= pc_addr;
        pc_data_o <= pc_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Randomized and directed bench for rf_wb_arbiter against a cycle-level reference
// model of the arbitration, write path and scoreboard rules.
module tb_rf_wb_arbiter;

  localparam int DW   = 16;
  localparam int AW   = 4;
  localparam int NREQ = 3;
  localparam int NR   = 2**AW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               pc_valid;
  logic [AW-1:0]      pc_addr;
  logic [DW-1:0]      pc_data;
  logic               issue_en;
  logic [AW-1:0]      issue_addr;
  logic               flush;
  logic [AW-1:0]      chk1_addr;
  logic [AW-1:0]      chk2_addr;
  logic               hazard1;
  logic               hazard2;
  logic [NR-1:0]      pending;
  logic               w_en;
  logic [AW-1:0]      w_addr;
  logic [DW-1:0]      w_data;
  logic               pc_en;
  logic [AW-1:0]      pc_addr_o;
  logic [DW-1:0]      pc_data_o;

  rf_wb_arbiter #(.DW(DW), .AW(AW), .NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .pc_valid(pc_valid), .pc_addr(pc_addr), .pc_data(pc_data),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush),
    .chk1_addr(chk1_addr), .chk2_addr(chk2_addr),
    .hazard1(hazard1), .hazard2(hazard2), .pending(pending),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .pc_en(pc_en), .pc_addr_o(pc_addr_o), .pc_data_o(pc_data_o)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_tests = 0;
  int n_fail  = 0;

  int              m_last;
  logic [NR-1:0]   m_pend;
  logic            m_w_en;
  logic [AW-1:0]   m_w_addr;
  logic [DW-1:0]   m_w_data;
  logic            m_pc_en;
  logic [AW-1:0]   m_pc_addr;
  logic [DW-1:0]   m_pc_data;
  logic [AW+DW-1:0] exp_q[$];
  int              last_g;
  bit              sticky;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: inputs already driven after a negedge.
  task automatic step();
    int g;
    logic [NR-1:0] np;
    logic [AW+DW-1:0] e;
    #1;
    g = -1;
    if (!pc_valid && !flush) begin
      for (int k = 1; k <= NREQ; k++) begin
        int j;
        j = (m_last + k) % NREQ;
        if (req_valid[j]) begin
          g = j;
          break;
        end
      end
    end
    check_eq("req_ready", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
    check_eq("hazard1", 32'(hazard1), 32'(m_pend[chk1_addr]));
    check_eq("hazard2", 32'(hazard2), 32'(m_pend[chk2_addr]));
    check_eq("pending", 32'(pending), 32'(m_pend));

    np = m_pend;
    if (flush) np = '0;
    else begin
      if (m_w_en) np[m_w_addr] = 1'b0;
      if (issue_en) np[issue_addr] = 1'b1;
    end
    m_pend = np;
    m_w_en = (g >= 0);
    if (g >= 0) begin
      m_last   = g;
      m_w_addr = req_addr[g*AW +: AW];
      m_w_data = req_data[g*DW +: DW];
      exp_q.push_back({m_w_addr, m_w_data});
    end
    m_pc_en = pc_valid;
    if (pc_valid) begin
      m_pc_addr = pc_addr;
      m_pc_data = pc_data;
    end

    @(posedge clk);
    #1;
    check_eq("w_en", 32'(w_en), 32'(m_w_en));
    check_eq("w_addr", 32'(w_addr), 32'(m_w_addr));
    check_eq("w_data", 32'(w_data), 32'(m_w_data));
    check_eq("pc_en", 32'(pc_en), 32'(m_pc_en));
    check_eq("pc_w_exclusive", 32'(pc_en & w_en), 32'd0);
    if (pc_en) begin
      check_eq("pc_addr_o", 32'(pc_addr_o), 32'(m_pc_addr));
      check_eq("pc_data_o", 32'(pc_data_o), 32'(m_pc_data));
    end
    if (w_en) begin
      if (exp_q.size() == 0) check_eq("wq_underflow", 32'(exp_q.size()), 32'd1);
      else begin
        e = exp_q.pop_front();
        check_eq("wq_write", 32'({w_addr, w_data}), 32'(e));
      end
    end
    last_g = g;
    if (g >= 0 && !sticky) req_valid[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_addr[i*AW +: AW]  = a;
    req_data[i*DW +: DW]  = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n      = 1'b0;
    req_valid  = '1;
    req_addr   = NREQ*AW'($urandom);
    req_data   = NREQ*DW'({$urandom, $urandom});
    pc_valid   = 1'b1;
    pc_addr    = AW'($urandom);
    pc_data    = DW'($urandom);
    issue_en   = 1'b1;
    issue_addr = AW'($urandom);
    flush      = 1'b1;
    chk1_addr  = '0;
    chk2_addr  = '0;
    sticky     = 1'b0;
    last_g     = -1;

    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_w_en", 32'(w_en), 32'd0);
    check_eq("rst_pc_en", 32'(pc_en), 32'd0);
    check_eq("rst_pending", 32'(pending), 32'd0);
    check_eq("rst_w_addr_data", 32'({w_addr, w_data}), 32'd0);
    check_eq("rst_pc_addr_data", 32'({pc_addr_o, pc_data_o}), 32'd0);

    @(negedge clk);
    req_valid = '0; pc_valid = 1'b0; issue_en = 1'b0; flush = 1'b0;
    rst_n     = 1'b1;
    m_last = NREQ - 1; m_pend = '0; m_w_en = 1'b0; m_w_addr = '0; m_w_data = '0;
    m_pc_en = 1'b0; m_pc_addr = '0; m_pc_data = '0;
    step();

    // all requesters valid: 0,1,2,0,1,2
    sticky = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, AW'(i + 1), DW'($urandom));
    for (int k = 0; k < 6; k++) begin
      step();
      check_eq("rr_order", 32'(last_g), 32'(k % NREQ));
    end
    sticky = 1'b0;
    req_valid = '0;
    step();

    // PC update has priority, general write follows
    set_req(1, AW'(5), DW'(16'hBEEF));
    pc_valid = 1'b1; pc_addr = AW'(15); pc_data = DW'(16'h0040);
    step();
    check_eq("pc_blocks_grant", 32'(last_g), 32'hFFFF_FFFF);
    pc_valid = 1'b0;
    step();
    check_eq("grant_after_pc", 32'(last_g), 32'd1);
    check_eq("beef_landed", 32'(w_data), 32'h0000_BEEF);
    step();

    // RAW hazard on r7 held through the write cycle
    chk1_addr = AW'(7);
    issue_en = 1'b1; issue_addr = AW'(7);
    step();
    issue_en = 1'b0;
    check_eq("hazard_set", 32'(hazard1), 32'd1);
    set_req(0, AW'(7), DW'($urandom));
    step();
    check_eq("hazard_hold", 32'(hazard1), 32'd1);
    step();
    check_eq("hazard_clear", 32'(hazard1), 32'd0);

    // issue beats same-edge clear on r4
    set_req(2, AW'(4), DW'($urandom));
    step();
    issue_en = 1'b1; issue_addr = AW'(4);
    step();
    issue_en = 1'b0;
    check_eq("set_wins", 32'(pending[4]), 32'd1);

    // flush with a request waiting
    for (int a = 5; a <= 7; a++) begin
      issue_en = 1'b1; issue_addr = AW'(a);
      step();
    end
    issue_en = 1'b0;
    check_eq("pend_f0", 32'(pending), 32'h0000_00F0);
    flush = 1'b1;
    set_req(0, AW'(9), DW'($urandom));
    step();
    flush = 1'b0;
    check_eq("flush_no_grant", 32'(last_g), 32'hFFFF_FFFF);
    check_eq("flush_clear", 32'(pending), 32'd0);
    step();
    check_eq("grant_after_flush", 32'(last_g), 32'd0);
    step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NREQ; i++)
        if (!req_valid[i] && $urandom_range(0, 1) == 1) set_req(i, AW'($urandom), DW'($urandom));
      pc_valid   = ($urandom_range(0, 9) < 2);
      pc_addr    = AW'($urandom);
      pc_data    = DW'($urandom);
      issue_en   = ($urandom_range(0, 2) == 0);
      issue_addr = AW'($urandom);
      flush      = ($urandom_range(0, 19) == 0);
      chk1_addr  = AW'($urandom);
      chk2_addr  = AW'($urandom);
      step();
    end
    pc_valid = 1'b0; issue_en = 1'b0; flush = 1'b0; req_valid = '0;
    step();
    check_eq("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
